envelope_sched: RTL and testbench

ENVELOPE_SCHED -- requirements
Module: envelope_sched

---
 rtl/envelope_pkg.sv | 14 +
 rtl/envelope_gen.sv | 37 +++
 rtl/envelope_sched.sv | 130 +++++++++++++
 tb/tb_envelope_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/envelope_pkg.sv
// Shared constants and FSM encoding for the voice envelope scheduler.
// Imported by envelope_gen and envelope_sched.
package envelope_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int VEL_W          = 7;
    localparam int PRESC_W        = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/envelope_gen.sv
// Single-voice envelope datapath: velocity minus a decay step chosen from
// key, note-end and sustain state. Ports: envelope_pulse/poly_start enable
// the step, velocity_sel in, velocity_out = raw modulo-2^VEL_W result.
module envelope_gen
    import envelope_pkg::*;
(
    input  logic             envelope_pulse,
    input  logic             poly_start,
    input  logic [VEL_W-1:0] velocity_sel,
    input  logic             key_pressed,
    input  logic             ended_note,
    input  logic             sustain,
    input  logic [3:0]       pedal_depth,
    output logic [VEL_W-1:0] velocity_out
);

    logic [VEL_W-1:0] dec;

    always_comb begin
        dec = '0;
        unique case (1'b1)
            key_pressed:
                dec = VEL_W'(1);
            !key_pressed && (ended_note || !sustain):
                dec = VEL_W'(15);
            // released but held by the pedal: deeper pedal, slower decay
            default:
                dec = VEL_W'(5'd16 - {1'b0, pedal_depth});
        endcase
    end

    // No underflow protection here; the scheduler saturates on write-back.
    assign velocity_out = (envelope_pulse && poly_start)
                        ? velocity_sel - dec
                        : velocity_sel;

endmodule

// File: rtl/envelope_sched.sv
// Time-shares one envelope_gen across NUM_VOICES voices: a prescaler makes
// an envelope tick, after which a sweep updates one voice per cycle.
// Ports: clk, rst (async high), en, key_on, note_start, start_velocity,
// sustain, pedal_depth in; voice_velocity, voice_active, tick_pulse,
// sweep_busy out.
module envelope_sched
    import envelope_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int TICK_DIV   = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_VOICES-1:0]       key_on,
    input  logic [NUM_VOICES-1:0]       note_start,
    input  logic [VEL_W-1:0]            start_velocity,
    input  logic                        sustain,
    input  logic [3:0]                  pedal_depth,
    output logic [VEL_W*NUM_VOICES-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic                        tick_pulse,
    output logic                        sweep_busy
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [PRESC_W-1:0] CNT_MAX  = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_VOICES - 1);

    logic [PRESC_W-1:0]    cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VEL_W-1:0]      vel_q [NUM_VOICES];
    logic [VEL_W-1:0]      vel_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [VEL_W-1:0]      cur_vel, gen_vel, wb_vel;
    logic                  cur_key;
    logic                  tick;

    assign tick       = en && (cnt_q == CNT_MAX);
    assign tick_pulse = tick;
    assign sweep_busy = (state_q == ST_SWEEP);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // The sweep ignores en once started so every voice gets its step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    assign cur_vel = vel_q[idx_q];
    assign cur_key = key_on[idx_q];

    envelope_gen u_gen (
        .envelope_pulse (1'b1),
        .poly_start     (1'b1),
        .velocity_sel   (cur_vel),
        .key_pressed    (cur_key),
        .ended_note     (!cur_key && !sustain),
        .sustain        (sustain),
        .pedal_depth    (pedal_depth),
        .velocity_out   (gen_vel)
    );

    // A result above the old value means the subtraction wrapped.
    assign wb_vel = (gen_vel > cur_vel) ? '0 : gen_vel;

    // A new note overrides the decay step landing on the same voice.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            vel_d[i] = vel_q[i];
            if (sweep_busy && (idx_q == IDX_W'(i))) begin
                vel_d[i] = wb_vel;
            end
            if (note_start[i]) begin
                vel_d[i] = start_velocity;
            end
            active_d[i] = (vel_d[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            active_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vel_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vel_q[i] <= vel_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_velocity[VEL_W*g +: VEL_W] = vel_q[g];
    end

    assign voice_active = active_q;

endmodule

// File: tb/tb_envelope_sched.sv
// Self-checking bench for envelope_sched (TICK_DIV=8, NUM_VOICES=4):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_envelope_sched;

    localparam int NV = 4;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NV-1:0] key_on;
    logic [NV-1:0] note_start;
    logic [6:0]    start_velocity;
    logic          sustain;
    logic [3:0]    pedal_depth;
    logic [7*NV-1:0] voice_velocity;
    logic [NV-1:0] voice_active;
    logic          tick_pulse;
    logic          sweep_busy;

    int checks = 0;
    int errors = 0;

    // model: velocities, en-cycle count since reset, cycle of voice0 step
    int m_vel [NV];
    int m_en_cnt;
    int m_cyc = 0;
    int m_sweep_at = -100;

    always #5 clk = ~clk;

    envelope_sched #(
        .NUM_VOICES (NV),
        .TICK_DIV   (TD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .key_on         (key_on),
        .note_start     (note_start),
        .start_velocity (start_velocity),
        .sustain        (sustain),
        .pedal_depth    (pedal_depth),
        .voice_velocity (voice_velocity),
        .voice_active   (voice_active),
        .tick_pulse     (tick_pulse),
        .sweep_busy     (sweep_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int decay(int v, bit k, bit s, int d);
        int step;
        step = k ? 1 : (!s ? 15 : 16 - d);
        return (v >= step) ? v - step : 0;
    endfunction

    // Called at a negedge with inputs already applied; checks, advances
    // the model across the next rising edge, returns at the next negedge.
    task automatic cycle();
        int  v;
        bit  tk;
        bit  busy;
        #1;
        for (int i = 0; i < NV; i++) begin
            chk("vel", voice_velocity[7*i +: 7], m_vel[i]);
            chk("active", voice_active[i], m_vel[i] != 0);
        end
        tk   = en && (m_en_cnt % TD == TD - 1);
        v    = m_cyc - m_sweep_at;
        busy = (v >= 0) && (v < NV);
        chk("tick", tick_pulse, tk);
        chk("busy", sweep_busy, busy);
        if (busy) begin
            m_vel[v] = decay(m_vel[v], key_on[v], sustain, int'(pedal_depth));
        end
        for (int i = 0; i < NV; i++) begin
            if (note_start[i]) m_vel[i] = int'(start_velocity);
        end
        if (en) m_en_cnt++;
        if (tk) m_sweep_at = m_cyc + 1;
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_vel", voice_velocity, 0);
        chk("rst_act", voice_active, 0);
        chk("rst_tick", tick_pulse, 0);
        chk("rst_busy", sweep_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        note_start = '0;
        for (int i = 0; i < NV; i++) m_vel[i] = 0;
        m_en_cnt   = 0;
        m_sweep_at = -100;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; key_on = '0; note_start = '0;
        start_velocity = '0; sustain = 1'b0; pedal_depth = '0;
        @(negedge clk);

        // held key on voice0, tick cadence
        do_reset();
        en = 1'b1; key_on = 4'b0001;
        note_start = 4'b0001; start_velocity = 7'd100;
        cycle();
        note_start = '0;
        run(6);
        #1 chk("first_tick", tick_pulse, 1);
        run(5);
        chk("v0_sweep1", voice_velocity[6:0], 99);
        chk("v123_zero", voice_velocity[27:7], 0);
        run(8);
        chk("v0_sweep2", voice_velocity[6:0], 98);

        // release without sustain saturates to 0
        do_reset();
        key_on = '0; sustain = 1'b0;
        note_start = 4'b0010; start_velocity = 7'd20;
        cycle();
        note_start = '0;
        run(11);
        chk("v1_sweep1", voice_velocity[13:7], 5);
        run(8);
        chk("v1_sat", voice_velocity[13:7], 0);
        chk("v1_inactive", voice_active[1], 0);

        // release with sustain pedal
        do_reset();
        sustain = 1'b1; pedal_depth = 4'd12;
        note_start = 4'b0100; start_velocity = 7'd50;
        cycle();
        note_start = '0;
        run(11);
        chk("v2_ped1", voice_velocity[20:14], 46);
        run(8);
        chk("v2_ped2", voice_velocity[20:14], 42);
        run(8);
        chk("v2_ped3", voice_velocity[20:14], 38);
        pedal_depth = 4'd0;
        run(8);
        chk("v2_depth0", voice_velocity[20:14], 22);

        // note_start collides with voice3's write-back
        do_reset();
        sustain = 1'b0; pedal_depth = '0;
        note_start = 4'b1000; start_velocity = 7'd30;
        cycle();
        note_start = '0;
        run(10);
        note_start = 4'b1000; start_velocity = 7'd70;
        cycle();
        note_start = '0;
        chk("v3_collide", voice_velocity[27:21], 70);

        // en drops mid-sweep, then rst mid-sweep
        do_reset();
        key_on = 4'b1111;
        note_start = 4'b1111; start_velocity = 7'd10;
        cycle();
        note_start = '0;
        run(8);
        en = 1'b0;
        run(6);
        chk("en_low_idle", sweep_busy, 0);
        chk("v3_en_low", voice_velocity[27:21], 9);
        en = 1'b1;
        run(7);
        #1 chk("busy_pre_rst", sweep_busy, 1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            en             = ($urandom_range(0, 9) != 0);
            key_on         = NV'($urandom);
            note_start     = ($urandom_range(0, 5) == 0) ? NV'($urandom) : '0;
            start_velocity = 7'($urandom);
            sustain        = 1'($urandom);
            pedal_depth    = 4'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
